// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine: RC4 key-scheduling engine driving a single-port synchronous S-memory.
// Define RC4_KSA_SHUFFLE_EN for identity fill plus KSA shuffle; otherwise it only fills S[i] = i.
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [ADDR_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [ADDR_W-1:0]      mem_rdata,
  output logic [ADDR_W-1:0]      progress
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] INIT = 4'd1;
`ifdef RC4_KSA_SHUFFLE_EN
  localparam logic [3:0] RD_I = 4'd2;
  localparam logic [3:0] LD_I = 4'd3;
  localparam logic [3:0] RD_J = 4'd4;
  localparam logic [3:0] LD_J = 4'd5;
  localparam logic [3:0] WR_I = 4'd6;
  localparam logic [3:0] WR_J = 4'd7;
`endif
  localparam logic [3:0] DONE = 4'd8;

  localparam logic [ADDR_W-1:0] LAST_I = '1;
  localparam logic [ADDR_W-1:0] ONE_I  = ADDR_W'(1);

  logic [3:0]        state;
  logic [ADDR_W-1:0] i;

`ifdef RC4_KSA_SHUFFLE_EN
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] LAST_K = KIDX_W'(KEY_BYTES - 1);
  localparam logic [KIDX_W-1:0] ONE_K  = KIDX_W'(1);

  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] si;
  logic [ADDR_W-1:0] j_new;
  logic [ADDR_W-1:0] key_reg [KEY_BYTES];
  logic [KIDX_W-1:0] key_idx;

  // Only meaningful in LD_I, where mem_rdata holds S[i]; key bytes come from the latched copy.
  assign j_new = j + mem_rdata + key_reg[key_idx];
`else
  logic unused_inputs;
  assign unused_inputs = ^{secret_key, mem_rdata};
`endif

  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);
  assign progress = i;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
`ifdef RC4_KSA_SHUFFLE_EN
      j       <= '0;
      si      <= '0;
      key_idx <= '0;
      for (int k = 0; k < KEY_BYTES; k++) key_reg[k] <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= INIT;
            i         <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b1;
`ifdef RC4_KSA_SHUFFLE_EN
            for (int k = 0; k < KEY_BYTES; k++)
              key_reg[k] <= secret_key[8*(KEY_BYTES-1-k) +: ADDR_W];
`endif
          end
        end
        INIT: begin
          if (i == LAST_I) begin
            mem_wren <= 1'b0;
`ifdef RC4_KSA_SHUFFLE_EN
            state    <= RD_I;
            i        <= '0;
            j        <= '0;
            key_idx  <= '0;
            mem_addr <= '0;
`else
            state    <= DONE;
`endif
          end else begin
            i         <= i + ONE_I;
            mem_addr  <= i + ONE_I;
            mem_wdata <= i + ONE_I;
          end
        end
`ifdef RC4_KSA_SHUFFLE_EN
        RD_I: state <= LD_I;
        LD_I: begin
          si       <= mem_rdata;
          j        <= j_new;
          mem_addr <= j_new;
          state    <= RD_J;
        end
        RD_J: state <= LD_J;
        // mem_wdata doubles as the sj holding register for the WR_I write.
        LD_J: begin
          mem_addr  <= i;
          mem_wdata <= mem_rdata;
          mem_wren  <= 1'b1;
          state     <= WR_I;
        end
        WR_I: begin
          mem_addr  <= j;
          mem_wdata <= si;
          state     <= WR_J;
        end
        WR_J: begin
          mem_wren <= 1'b0;
          if (i == LAST_I) begin
            state <= DONE;
          end else begin
            i        <= i + ONE_I;
            mem_addr <= i + ONE_I;
            key_idx  <= (key_idx == LAST_K) ? '0 : key_idx + ONE_K;
            state    <= RD_I;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb_rc4_ksa_engine: directed bench with a write scoreboard fed by a software RC4 KSA model.
// Follows RC4_KSA_SHUFFLE_EN so the expected write stream matches the build under test.
module tb_rc4_ksa_engine;

`ifdef RC4_KSA_SHUFFLE_EN
  localparam bit SHUF = 1'b1;
`else
  localparam bit SHUF = 1'b0;
`endif
  localparam int MID_START = SHUF ? 500 : 100;
  localparam int RESET_AT  = SHUF ? 600 : 150;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        start_a  = 1'b0;
  logic        start_b  = 1'b0;
  logic [23:0] key_a    = '0;
  logic [7:0]  key_b    = '0;

  logic       busy_a, done_a, wren_a;
  logic [7:0] addr_a, wdata_a, rdata_a, prog_a;
  logic       busy_b, done_b, wren_b;
  logic [1:0] addr_b, wdata_b, rdata_b, prog_b;

  logic [7:0] mem_a [256];
  logic [1:0] mem_b [4];

  int          cyc = 0;
  int          t0_a = 0;
  int          t0_b = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb_a [$];
  logic [31:0] sb_b [$];
  int          exp_a [256];
  int          exp_b [256];

  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start_a), .secret_key(key_a),
    .busy(busy_a), .done(done_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_wren(wren_a), .mem_rdata(rdata_a), .progress(prog_a)
  );

  rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(1)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start_b), .secret_key(key_b),
    .busy(busy_b), .done(done_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_wren(wren_b), .mem_rdata(rdata_b), .progress(prog_b)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Single-port synchronous S-memories: q is the old contents of the presented address.
  always @(posedge CLOCK_50) begin
    if (wren_a) mem_a[addr_a] <= wdata_a;
    rdata_a <= mem_a[addr_a];
    if (wren_b) mem_b[addr_b] <= wdata_b;
    rdata_b <= mem_b[addr_b];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard entries pack {cycle after accept, addr, data}.
  task automatic pushExp(input bit which, input int cycle, input int addr, input int data);
    logic [31:0] e;
    e = {16'(cycle), 8'(addr), 8'(data)};
    if (which) sb_b.push_back(e);
    else       sb_a.push_back(e);
  endtask

  task automatic buildExpected(input bit which, input int n, input logic [23:0] key, input int kbytes);
    int s [256];
    int j, kb, tmp;
    for (int k = 0; k < n; k++) begin
      s[k] = k;
      pushExp(which, k + 1, k, k);
    end
    if (SHUF) begin
      j = 0;
      for (int i = 0; i < n; i++) begin
        kb  = int'((key >> (8 * (kbytes - 1 - (i % kbytes)))) & 24'hFF) % n;
        j   = (j + s[i] + kb) % n;
        pushExp(which, n + 6*i + 5, i, s[j]);
        pushExp(which, n + 6*i + 6, j, s[i]);
        tmp  = s[i];
        s[i] = s[j];
        s[j] = tmp;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (which) exp_b[k] = s[k];
      else       exp_a[k] = s[k];
    end
  endtask

  task automatic checkWrite(input bit which, input int addr, input int data);
    logic [31:0] obs;
    int t0;
    t0  = which ? t0_b : t0_a;
    obs = {16'(cyc - t0 + 1), 8'(addr), 8'(data)};
    if (which) begin
      if (sb_b.size() == 0) checkOutput("b_unexpected_write", obs, 32'h0);
      else                  checkOutput("b_write_cyc_addr_data", obs, sb_b.pop_front());
    end else begin
      if (sb_a.size() == 0) checkOutput("a_unexpected_write", obs, 32'h0);
      else                  checkOutput("a_write_cyc_addr_data", obs, sb_a.pop_front());
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (wren_a) checkWrite(1'b0, int'(addr_a), int'(wdata_a));
    if (wren_b) checkWrite(1'b1, int'(addr_b), int'(wdata_b));
  end

  // Drives an accepted start, records the accept edge and loads the expected write stream.
  task automatic applyStimulus(input bit which, input logic [23:0] key, input int kbytes);
    @(negedge CLOCK_50);
    if (which) begin key_b = key[7:0]; start_b = 1'b1; end
    else       begin key_a = key;      start_a = 1'b1; end
    @(posedge CLOCK_50);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (which) t0_b = cyc;
    else       t0_a = cyc;
    buildExpected(which, which ? 4 : 256, key, kbytes);
    @(negedge CLOCK_50);
    checkOutput(which ? "b_busy_cycle1" : "a_busy_cycle1", which ? busy_b : busy_a, 1);
    checkOutput(which ? "b_done_cycle1" : "a_done_cycle1", which ? done_b : done_a, 0);
    checkOutput(which ? "b_progress_cycle1" : "a_progress_cycle1",
                which ? 32'(prog_b) : 32'(prog_a), 0);
  endtask

  task automatic waitCycle(input int target);
    for (int c = 0; c < target + 10; c++) begin
      if (cyc - t0_a + 1 >= target) break;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic waitDone(input bit which, input string tag);
    bit   seen;
    logic prev_busy;
    int   n;
    seen      = 1'b0;
    prev_busy = 1'b0;
    n         = which ? 4 : 256;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLOCK_50);
      if (which ? done_b : done_a) begin
        seen = 1'b1;
        break;
      end
      prev_busy = which ? busy_b : busy_a;
    end
    if (!seen) begin
      checkOutput({tag, "_timeout"}, which ? done_b : done_a, 1);
    end else begin
      checkOutput({tag, "_done_cycle"}, cyc - (which ? t0_b : t0_a) + 1, SHUF ? 7*n + 1 : n + 1);
      checkOutput({tag, "_busy_at_done"}, which ? busy_b : busy_a, 0);
      checkOutput({tag, "_busy_before_done"}, prev_busy, 1);
    end
    checkOutput({tag, "_sb_leftover"}, which ? sb_b.size() : sb_a.size(), 0);
  endtask

  task automatic checkMemory(input bit which, input string tag);
    int         nbad;
    logic [7:0] v;
    nbad = 0;
    for (int k = 0; k < (which ? 4 : 256); k++) begin
      v = which ? 8'(mem_b[k]) : mem_a[k];
      if (v !== 8'(which ? exp_b[k] : exp_a[k])) nbad++;
    end
    checkOutput({tag, "_final_S_bad_bytes"}, nbad, 0);
  endtask

  initial begin
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    checkOutput("a_reset_busy", busy_a, 0);
    checkOutput("a_reset_done", done_a, 0);
    checkOutput("a_reset_wren", wren_a, 0);
    checkOutput("a_reset_addr", addr_a, 0);
    checkOutput("a_reset_progress", prog_a, 0);
    checkOutput("b_reset_done", done_b, 0);
    checkOutput("b_reset_wren", wren_b, 0);

    $display("[TB] small memory, key 8'h00");
    applyStimulus(1'b1, 24'h000000, 1);
    waitDone(1'b1, "b_run");
    checkMemory(1'b1, "b_run");

    $display("[TB] full run, key 24'h00033C");
    applyStimulus(1'b0, 24'h00033C, 3);
    waitDone(1'b0, "a_run1");
    checkMemory(1'b0, "a_run1");

    $display("[TB] key change and start while busy");
    applyStimulus(1'b0, 24'h00033C, 3);
    waitCycle(MID_START);
    key_a   = 24'hFFFFFF;
    start_a = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start_a = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("a_busy_after_ignored_start", busy_a, 1);
    waitDone(1'b0, "a_run2");
    checkMemory(1'b0, "a_run2");

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 24'h00033C, 3);
    waitCycle(RESET_AT);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    sb_a.delete();
    @(negedge CLOCK_50);
    checkOutput("a_midreset_wren", wren_a, 0);
    checkOutput("a_midreset_busy", busy_a, 0);
    checkOutput("a_midreset_done", done_a, 0);
    checkOutput("a_midreset_progress", prog_a, 0);
    applyStimulus(1'b0, 24'h00033C, 3);
    waitDone(1'b0, "a_run3");
    checkMemory(1'b0, "a_run3");

    $display("[TB] restart from done");
    repeat (5) @(negedge CLOCK_50);
    checkOutput("a_done_held", done_a, 1);
    applyStimulus(1'b0, 24'h00033C, 3);
    waitDone(1'b0, "a_run4");
    checkMemory(1'b0, "a_run4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
# rc4_ksa_engine

- Parametrised RC4 key-scheduling engine.
- Drives a single-port synchronous S-memory through two phases after a `start` request:
  - identity fill: S[i] = i;
  - optional KSA shuffle: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- Sits between the top-level control (switches/keys) and the `s_memory` instance. Later decrypt stages consume the result.

## Interface
- `ADDR_W`, default 8: S-memory address and data width, legal range 2..8. Depth N = 2^ADDR_W.
- `KEY_BYTES`, default 3: number of 8-bit key bytes.
- `CLOCK_50`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `secret_key`  in  8*KEY_BYTES  key. Byte 0 is the most significant byte, bits [8*KEY_BYTES-1 -: 8].
- `busy`  out  1  high from the accept edge until done rises.
- `done`  out  1  high while in DONE.
- `mem_addr`  out  ADDR_W  S-memory address, registered.
- `mem_wdata`  out  ADDR_W  S-memory write data, registered.
- `mem_wren`  out  1  S-memory write enable, registered.
- `mem_rdata`  in  ADDR_W  S-memory q. Valid in the cycle after the cycle in which `mem_addr` was presented.
- `progress`  out  ADDR_W  current i, for the LED display.

## Operation
- States: IDLE, INIT, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, DONE.
- Reset values, taking effect at the reset edge: state = IDLE; i = 0; j = 0; all outputs 0.
- **IDLE / DONE:**
  - On `start` = 1, latch `secret_key` into an internal key register and go to INIT with i = 0.
  - When accepted in DONE, `done` clears on the same edge.
- **INIT:**
  - Each cycle: `mem_addr` = i, `mem_wdata` = i, `mem_wren` = 1.
  - i increments modulo N.
  - After the write of i = N-1, go to RD_I with i = 0 and j = 0 (shuffle compiled in), or to DONE (shuffle compiled out).
- **RD_I:** `mem_addr` = i, `mem_wren` = 0.
- **LD_I:**
  - Latch si = `mem_rdata`.
  - Compute j_new = (j + si + kb) mod N, where kb = key byte (i mod KEY_BYTES) truncated to ADDR_W bits.
  - Register j = j_new and `mem_addr` = j_new for RD_J.
- **RD_J:** wait one cycle for the read of S[j].
- **LD_J:** latch sj = `mem_rdata`.
- **WR_I:** `mem_addr` = i, `mem_wdata` = sj, `mem_wren` = 1.
- **WR_J:** `mem_addr` = j, `mem_wdata` = si, `mem_wren` = 1. Then:
  - if i = N-1, go to DONE;
  - otherwise i increments and the FSM returns to RD_I.
- **Arithmetic:** all index arithmetic wraps modulo N. The key-byte index is a separate counter wrapping at KEY_BYTES; no divider.
- **Boundary conditions:**
  - i = j: both writes target the same location with equal data, so the net result is unchanged. Legal; no special case.
  - `start` while busy: ignored.
  - `secret_key` changes while busy: ignored, because the key register is used.
  - Reset mid-operation: at the reset edge, FSM returns to IDLE and `mem_wren` = 0. Memory contents are left partial and undefined.
- `mem_wren` is 0 in IDLE, RD_I, LD_I, RD_J, LD_J and DONE.

## Timing
- Accept edge E0 (`start` sampled in IDLE or DONE). INIT writes occupy cycles 1..N after E0.
- Shuffle takes exactly 6 cycles per i, occupying cycles N+1..7N.
- `done` rises at cycle 7N+1 after E0 (1793 for N = 256). With the shuffle compiled out, it rises at N+1 (257).
- `busy` = 1 from cycle 1 through the last write cycle, i.e. until `done` rises.
- `done` stays high until reset or a new accept. If `start` is held high, the engine restarts from DONE after 1 cycle.
- `progress` always equals the internal i register.

## Configuration
- `RC4_KSA_SHUFFLE_EN`:
  - **Defined:** full fill plus shuffle, as above.
  - **Undefined:** shuffle states, j, si/sj and the key register are not built. The FSM goes INIT → DONE and the engine is an N-cycle identity initialiser.

## Test plan
1. `RC4_KSA_SHUFFLE_EN` undefined, ADDR_W = 8: pulse `start` → 256 consecutive writes with addr = data = 0..255 on cycles 1..256; `done` = 1 at cycle 257, `busy` = 0.
2. Shuffle defined, ADDR_W = 2, KEY_BYTES = 1, key = 8'h00: start → memory model ends [0,2,3,1]. Includes the i = j swaps at i = 0 and i = 1. `done` at cycle 29.
3. ADDR_W = 8, KEY_BYTES = 3, key = 24'h00033C: start → final S matches a software RC4 KSA model byte-for-byte; `done` at cycle 1793.
4. Same setup as 3; change `secret_key` to 24'hFFFFFF and pulse `start` at cycle 500 → no effect; result still matches 24'h00033C; `done` at 1793.
5. Assert `reset` for 1 cycle at cycle 600 → next edge: `mem_wren` = 0, `busy` = 0, `done` = 0, `progress` = 0. A new start gives a correct result at 1793 cycles.
6. From DONE, pulse `start` → `done` clears on the accept edge and a full rerun completes, with `done` again at cycle 1793.
